router_port_rx: RTL and testbench
=================================

// Module: router_port_rx
// PURPOSE
//  Downstream consumer for one Router1x3 output port (data_out_N / vld_out_N / read_enb_N).
//  - Drains the router FIFO and parses the packet: header {len[5:0], addr[1:0]}, then len payload bytes, then a parity byte.
//  - Forwards payload on a valid/ready byte stream with sop/eop markers.
//  - Checks XOR parity and the address field, and reports one status pulse per packet.
// PARAMETERS
//  PORT_ID    2'd0  expected addr field; a mismatch flags addr_err
//  BUF_DEPTH  4     payload skid-buffer entries (power of 2, >=2)
//  STALL_TO   32    cycles mid-packet with no byte before abort; must stay above router soft-reset window (30)
// PORTS
//  clk          in   1  single clock, rising edge
//  reset        in   1  asynchronous, active-high reset
//  vld_out_i    in   1  router port non-empty
//  data_out_i   in   8  router read data, valid 1 cycle after read_enb_o sampled high
//  read_enb_o   out  1  router read enable
//  m_data       out  8  payload byte
//  m_valid      out  1  m_data valid
//  m_sop        out  1  first payload byte of packet
//  m_eop        out  1  last payload byte of packet
//  m_ready      in   1  downstream accept
//  pkt_done     out  1  1-cycle pulse: parity byte consumed
//  parity_err   out  1  qualified by pkt_done: computed XOR != received parity
//  addr_err     out  1  qualified by pkt_done: hdr[1:0] != PORT_ID
//  trunc_err    out  1  1-cycle pulse: packet aborted by stall timeout
// BEHAVIOUR
//  Reset: all outputs 0; FSM=S_HDR; buffer empty; rd_pend=0; counters 0.
//  Read issue: read_enb_o = vld_out_i && (buf_cnt + rd_pend) < BUF_DEPTH, combinational.
//   rd_pend is a 1-bit register set when a read is issued; the returned byte is captured on the next edge.
//  FSM advances only on a captured byte ("rx"):
//   S_HDR: rx -> latch len=hdr[7:2] and addr; par=hdr; rem=len.
//          If len==0 go to S_PAR (no payload emitted), else go to S_PLD.
//   S_PLD: rx -> push {byte, sop=(rem==len), eop=(rem==1)}; par^=byte; rem--; at rem==1 go to S_PAR.
//   S_PAR: rx -> pulse pkt_done; parity_err=(par!=byte); addr_err; go to S_HDR.
//  Payload buffer: sop/eop travel with the data.
//   Push and pop in the same cycle leave buf_cnt unchanged.
//   m_valid = buf_cnt!=0; pop on m_valid && m_ready.
//   The read gate makes overflow impossible; an overflow push is an assertion failure.
//  Packets run back to back: a header byte may be captured the cycle after the parity byte, with no bubble.
//  Stall: in S_PLD/S_PAR, stall_cnt increments each cycle with no rx and clears on rx.
//   At stall_cnt==STALL_TO-1: pulse trunc_err, return to S_HDR.
//   Bytes already buffered still drain; no eop is synthesised.
//  A reset asserted mid-packet discards the buffer and the partial packet immediately.
// CONFIGURATION
//  ROUTER_PORT_RX_STATS_EN defined:
//   adds outputs pkt_cnt[15:0] (pkt_done count), err_cnt[15:0] (parity|addr|trunc events), and a saturating input clr_stats (sync clear).
//  Undefined: the ports and logic are absent; behaviour is otherwise identical.
// STRUCTURE
//  Shared package router_pkg:
//   - state enum (S_HDR, S_PLD, S_PAR)
//   - header field localparams LEN_MSB=7, LEN_LSB=2, ADDR_W=2
//   - PKT_LEN_MAX=63
//  Sub-module: router_rx_skid. A BUF_DEPTH x 10-bit sync FIFO carrying {eop, sop, data}, exporting cnt.
//  Top level holds the FSM, parity/remaining counters, stall timer, read gate and stats.
// TESTING
//  1. len=14, addr=0, PORT_ID=0, random payload, m_ready=1 -> 14 bytes out; sop on byte 0, eop on byte 13; pkt_done with both errors 0.
//  2. len=5 with parity byte corrupted (xor 8'h01) -> 5 bytes forwarded; pkt_done with parity_err=1.
//  3. len=16, m_ready low for 20 cycles mid-packet -> read_enb_o drops once buf_cnt+rd_pend==4; no byte lost or duplicated; resumes on m_ready.
//  4. len=0 header 8'h00, then parity 8'h00 -> no m_valid; pkt_done with parity_err=0.
//  5. Two back-to-back packets (len 3 then 2) -> exactly 2 sop/eop pairs and 2 pkt_done pulses; second header parsed without an idle cycle.
//  6. vld_out_i held low for 32 cycles after 4 of 10 payload bytes -> trunc_err pulse; the next header is parsed correctly.
//  Reset asserted mid-payload -> all outputs 0 the same cycle; next packet is clean.

Source files
------------

// File: rtl/router_pkg.sv
// Shared types and header-field constants for the router output-port receiver.
// Contents: FSM state enum, header bit positions, maximum payload length.
package router_pkg;

   typedef enum logic [1:0] {
      S_HDR = 2'd0,
      S_PLD = 2'd1,
      S_PAR = 2'd2
   } state_e;

   localparam int LEN_MSB     = 7;
   localparam int LEN_LSB     = 2;
   localparam int ADDR_W      = 2;
   localparam int PKT_LEN_MAX = 63;

   // Payload length field width, sized from the largest legal length.
   localparam int LEN_W = $clog2(PKT_LEN_MAX + 1);

endpackage

// File: rtl/router_rx_skid.sv
// Payload skid buffer: DEPTH x W synchronous FIFO with occupancy output.
// Ports: clk_i/rst_i (async high), push_i/data_i write, pop_i read, data_o head (0 when empty), cnt_o.
module router_rx_skid #(
   parameter int DEPTH = 4,
   parameter int W     = 10,
   localparam int AW   = $clog2(DEPTH),
   localparam int CW   = AW + 1
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          push_i,
   input  logic [W-1:0]  data_i,
   input  logic          pop_i,
   output logic [W-1:0]  data_o,
   output logic [CW-1:0] cnt_o
);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_q;
   logic [AW-1:0] rd_q;
   logic [CW-1:0] cnt_q;
   logic          do_pop;

   assign do_pop = pop_i && (cnt_q != '0);
   assign cnt_o  = cnt_q;
   // Head is masked while empty so every output reads 0 out of reset.
   assign data_o = (cnt_q != '0) ? mem[rd_q] : '0;

   always_ff @(posedge clk_i) begin
      if (push_i) mem[wr_q] <= data_i;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (push_i) wr_q <= wr_q + AW'(1);
         if (do_pop) rd_q <= rd_q + AW'(1);
         unique case ({push_i, do_pop})
            2'b10:   cnt_q <= cnt_q + CW'(1);
            2'b01:   cnt_q <= cnt_q - CW'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   // The upstream read gate must never let a push land on a full buffer.
   a_no_overflow : assert property (@(posedge clk_i) disable iff (rst_i)
      !(push_i && !do_pop && (cnt_q == CW'(DEPTH))));

endmodule

// File: rtl/router_port_rx.sv
// Router1x3 output-port consumer: drains the port FIFO, parses {len,addr} header,
// payload and XOR parity byte, forwards payload as a valid/ready stream with sop/eop,
// and reports per-packet status (pkt_done/parity_err/addr_err) or a stall abort (trunc_err).
// Ports: clk, reset (async high); vld_out_i/data_out_i/read_enb_o to the router;
// m_data/m_valid/m_sop/m_eop/m_ready downstream; status pulses.
// Optional: ROUTER_PORT_RX_STATS_EN adds clr_stats, pkt_cnt, err_cnt (saturating).
module router_port_rx
   import router_pkg::*;
#(
   parameter logic [ADDR_W-1:0] PORT_ID   = 2'd0,
   parameter int                BUF_DEPTH = 4,
   parameter int                STALL_TO  = 32
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       vld_out_i,
   input  logic [7:0] data_out_i,
   output logic       read_enb_o,
   output logic [7:0] m_data,
   output logic       m_valid,
   output logic       m_sop,
   output logic       m_eop,
   input  logic       m_ready,
   output logic       pkt_done,
   output logic       parity_err,
   output logic       addr_err,
   output logic       trunc_err
`ifdef ROUTER_PORT_RX_STATS_EN
   ,
   input  logic        clr_stats,
   output logic [15:0] pkt_cnt,
   output logic [15:0] err_cnt
`endif
);

   localparam int CW = $clog2(BUF_DEPTH) + 1;
   localparam int SW = $clog2(STALL_TO) + 1;

   state_e            state_q;
   logic [LEN_W-1:0]  len_q;
   logic [LEN_W-1:0]  rem_q;
   logic [ADDR_W-1:0] addr_q;
   logic [7:0]        par_q;
   logic [SW-1:0]     stall_q;
   logic              rd_pend_q;
   logic              pkt_done_q;
   logic              parity_err_q;
   logic              addr_err_q;
   logic              trunc_err_q;

   logic [CW-1:0]    buf_cnt;
   logic [CW:0]      inflight;
   logic             rx;
   logic [LEN_W-1:0] hdr_len;
   logic             push;
   logic [9:0]       push_data;
   logic [9:0]       head;
   logic             stall_hit;
   logic             par_bad;
   logic             addr_bad;

   // Bytes already buffered plus the one in flight bound the read gate.
   assign inflight   = {1'b0, buf_cnt} + (CW + 1)'(rd_pend_q);
   assign read_enb_o = !reset && vld_out_i
                    && (inflight < (CW + 1)'(BUF_DEPTH));

   assign rx        = rd_pend_q;
   assign hdr_len   = data_out_i[LEN_MSB:LEN_LSB];
   assign push      = rx && (state_q == S_PLD);
   assign push_data = {rem_q == LEN_W'(1), rem_q == len_q, data_out_i};
   assign stall_hit = (state_q != S_HDR) && !rx
                   && (stall_q == SW'(STALL_TO - 1));
   assign par_bad   = par_q != data_out_i;
   assign addr_bad  = addr_q != PORT_ID;

   router_rx_skid #(
      .DEPTH (BUF_DEPTH),
      .W     (10)
   ) u_skid (
      .clk_i  (clk),
      .rst_i  (reset),
      .push_i (push),
      .data_i (push_data),
      .pop_i  (m_valid && m_ready),
      .data_o (head),
      .cnt_o  (buf_cnt)
   );

   assign {m_eop, m_sop, m_data} = head;
   assign m_valid    = buf_cnt != '0;
   assign pkt_done   = pkt_done_q;
   assign parity_err = parity_err_q;
   assign addr_err   = addr_err_q;
   assign trunc_err  = trunc_err_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) rd_pend_q <= 1'b0;
      else       rd_pend_q <= read_enb_o;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= S_HDR;
         len_q        <= '0;
         rem_q        <= '0;
         addr_q       <= '0;
         par_q        <= '0;
         stall_q      <= '0;
         pkt_done_q   <= 1'b0;
         parity_err_q <= 1'b0;
         addr_err_q   <= 1'b0;
         trunc_err_q  <= 1'b0;
      end else begin
         pkt_done_q   <= 1'b0;
         parity_err_q <= 1'b0;
         addr_err_q   <= 1'b0;
         trunc_err_q  <= 1'b0;
         unique case (state_q)
            S_HDR: begin
               stall_q <= '0;
               if (rx) begin
                  len_q   <= hdr_len;
                  rem_q   <= hdr_len;
                  addr_q  <= data_out_i[ADDR_W-1:0];
                  par_q   <= data_out_i;
                  state_q <= (hdr_len == '0) ? S_PAR : S_PLD;
               end
            end
            S_PLD: begin
               if (rx) begin
                  stall_q <= '0;
                  par_q   <= par_q ^ data_out_i;
                  rem_q   <= rem_q - LEN_W'(1);
                  if (rem_q == LEN_W'(1)) state_q <= S_PAR;
               end else if (stall_hit) begin
                  stall_q     <= '0;
                  trunc_err_q <= 1'b1;
                  state_q     <= S_HDR;
               end else begin
                  stall_q <= stall_q + SW'(1);
               end
            end
            S_PAR: begin
               if (rx) begin
                  stall_q      <= '0;
                  pkt_done_q   <= 1'b1;
                  parity_err_q <= par_bad;
                  addr_err_q   <= addr_bad;
                  state_q      <= S_HDR;
               end else if (stall_hit) begin
                  stall_q     <= '0;
                  trunc_err_q <= 1'b1;
                  state_q     <= S_HDR;
               end else begin
                  stall_q <= stall_q + SW'(1);
               end
            end
            default: state_q <= S_HDR;
         endcase
      end
   end

`ifdef ROUTER_PORT_RX_STATS_EN
   logic [15:0] pkt_cnt_q;
   logic [15:0] err_cnt_q;
   logic        ev_done;
   logic        ev_err;

   assign ev_done = rx && (state_q == S_PAR);
   assign ev_err  = (ev_done && (par_bad || addr_bad)) || stall_hit;
   assign pkt_cnt = pkt_cnt_q;
   assign err_cnt = err_cnt_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pkt_cnt_q <= '0;
         err_cnt_q <= '0;
      end else if (clr_stats) begin
         pkt_cnt_q <= '0;
         err_cnt_q <= '0;
      end else begin
         if (ev_done && (pkt_cnt_q != '1)) pkt_cnt_q <= pkt_cnt_q + 16'd1;
         if (ev_err && (err_cnt_q != '1))  err_cnt_q <= err_cnt_q + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_router_port_rx.sv
// Self-checking bench for router_port_rx: router FIFO model, payload/status
// scoreboard, table of packets plus backpressure, back-to-back, stall and reset sequences.
module tb_router_port_rx;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       vld_out_i = 1'b0;
   logic [7:0] data_out_i = 8'h00;
   logic       m_ready = 1'b0;
   logic       read_enb_o;
   logic [7:0] m_data;
   logic       m_valid;
   logic       m_sop;
   logic       m_eop;
   logic       pkt_done;
   logic       parity_err;
   logic       addr_err;
   logic       trunc_err;
`ifdef ROUTER_PORT_RX_STATS_EN
   logic        clr_stats = 1'b0;
   logic [15:0] pkt_cnt;
   logic [15:0] err_cnt;
`endif

   always #5 clk = ~clk;

   router_port_rx dut (
      .clk        (clk),
      .reset      (reset),
      .vld_out_i  (vld_out_i),
      .data_out_i (data_out_i),
      .read_enb_o (read_enb_o),
      .m_data     (m_data),
      .m_valid    (m_valid),
      .m_sop      (m_sop),
      .m_eop      (m_eop),
      .m_ready    (m_ready),
      .pkt_done   (pkt_done),
      .parity_err (parity_err),
      .addr_err   (addr_err),
      .trunc_err  (trunc_err)
`ifdef ROUTER_PORT_RX_STATS_EN
      ,
      .clr_stats  (clr_stats),
      .pkt_cnt    (pkt_cnt),
      .err_cnt    (err_cnt)
`endif
   );

   logic [7:0] rq[$];
   logic [9:0] exp_q[$];
   logic [1:0] st_q[$];
   int         exp_trunc = 0;
   int         checks = 0;
   int         failures = 0;
   int         cyc = 0;
   int         done_cnt = 0;
   int         last_done = 0;
   int         prev_done = 0;
   logic       rd_issue = 1'b0;

   // Router FIFO model: a read sampled high returns its byte one cycle later.
   always @(negedge clk) rd_issue = read_enb_o;

   always @(posedge clk) begin
      if (rd_issue && rq.size() != 0) data_out_i <= rq.pop_front();
      vld_out_i <= rq.size() != 0;
   end

   // Scoreboard: payload bytes and status pulses are checked as they appear.
   always @(negedge clk) begin
      cyc++;
      if (!reset) begin
         if (m_valid && m_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL byte_extra actual=%h required=none", {m_eop, m_sop, m_data});
            end else begin
               logic [9:0] e;
               e = exp_q.pop_front();
               if ({m_eop, m_sop, m_data} !== e) begin
                  failures++;
                  $display("FAIL byte actual={eop,sop,data}=%h required=%h", {m_eop, m_sop, m_data}, e);
               end
            end
         end
         if (pkt_done) begin
            done_cnt++;
            prev_done = last_done;
            last_done = cyc;
            checks++;
            if (st_q.size() == 0) begin
               failures++;
               $display("FAIL pkt_done_extra actual=1 required=0");
            end else begin
               logic [1:0] s;
               s = st_q.pop_front();
               if ({parity_err, addr_err} !== s) begin
                  failures++;
                  $display("FAIL status actual={perr,aerr}=%b required=%b", {parity_err, addr_err}, s);
               end
            end
         end
         if (trunc_err) begin
            checks++;
            if (exp_trunc == 0) begin
               failures++;
               $display("FAIL trunc_extra actual=1 required=0");
            end else begin
               exp_trunc--;
            end
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic send_pkt(input int len, input logic [1:0] addr, input logic corrupt,
                           input logic perr, input logic aerr);
      logic [7:0] hdr, par, b;
      hdr = {len[5:0], addr};
      par = hdr;
      rq.push_back(hdr);
      for (int i = 0; i < len; i++) begin
         b = 8'($urandom);
         rq.push_back(b);
         par ^= b;
         exp_q.push_back({i == len - 1, i == 0, b});
      end
      rq.push_back(par ^ {7'd0, corrupt});
      st_q.push_back({perr, aerr});
   endtask

   task automatic send_partial(input int len, input int n);
      logic [7:0] b;
      rq.push_back({len[5:0], 2'd0});
      for (int i = 0; i < n; i++) begin
         b = 8'($urandom);
         rq.push_back(b);
         exp_q.push_back({1'b0, i == 0, b});
      end
      exp_trunc++;
   endtask

   task automatic wait_idle(input int budget, input string name);
      int n;
      n = 0;
      while ((rq.size() != 0 || exp_q.size() != 0 || st_q.size() != 0 || exp_trunc != 0)
             && n < budget) begin
         step(1);
         n++;
      end
      checks++;
      if (n >= budget) begin
         failures++;
         $display("FAIL %s_timeout actual=pending(%0d,%0d,%0d,%0d) required=idle",
                  name, rq.size(), exp_q.size(), st_q.size(), exp_trunc);
      end
      step(4);
   endtask

   typedef struct {
      int         len;
      logic [1:0] addr;
      logic       corrupt;
      logic       perr;
      logic       aerr;
   } vec_t;

   vec_t vt[6];

   initial begin
      vt[0] = '{14, 2'd0, 1'b0, 1'b0, 1'b0};
      vt[1] = '{5,  2'd0, 1'b1, 1'b1, 1'b0};
      vt[2] = '{0,  2'd0, 1'b0, 1'b0, 1'b0};
      vt[3] = '{7,  2'd2, 1'b0, 1'b0, 1'b1};
      vt[4] = '{1,  2'd1, 1'b1, 1'b1, 1'b1};
      vt[5] = '{63, 2'd0, 1'b0, 1'b0, 0};

      m_ready = 1'b1;
      reset   = 1'b1;
      send_pkt(2, 2'd0, 1'b0, 1'b0, 1'b0);
      step(3);
      chk("rst_vld_seen", 32'(vld_out_i), 32'd1);
      chk("rst_outputs",
          32'({read_enb_o, m_valid, m_sop, m_eop, m_data, pkt_done, parity_err, addr_err, trunc_err}),
          32'd0);
      reset = 1'b0;
      wait_idle(100, "first");

      for (int i = 0; i < 6; i++) begin
         send_pkt(vt[i].len, vt[i].addr, vt[i].corrupt, vt[i].perr, vt[i].aerr);
         wait_idle(400, $sformatf("vec%0d", i));
      end

      begin
         int n, rd_n;
         send_pkt(16, 2'd0, 1'b0, 1'b0, 1'b0);
         n = 0;
         while (exp_q.size() > 13 && n < 100) begin
            step(1);
            n++;
         end
         chk("bp_start", 32'(n < 100), 32'd1);
         m_ready = 1'b0;
         rd_n = 0;
         for (int i = 0; i < 20; i++) begin
            rd_n += int'(read_enb_o);
            step(1);
         end
         chk("bp_gate", 32'({read_enb_o, vld_out_i}), 32'b01);
         chk("bp_reads_le4", 32'(rd_n <= 4), 32'd1);
         m_ready = 1'b1;
         wait_idle(400, "bp");
      end

      begin
         int d0;
         d0 = done_cnt;
         send_pkt(3, 2'd0, 1'b0, 1'b0, 1'b0);
         send_pkt(2, 2'd0, 1'b0, 1'b0, 1'b0);
         wait_idle(200, "b2b");
         chk("b2b_done_cnt", 32'(done_cnt - d0), 32'd2);
         chk("b2b_gap", 32'(last_done - prev_done), 32'd4);
      end

      send_partial(10, 4);
      wait_idle(200, "stall");
      send_pkt(6, 2'd0, 1'b0, 1'b0, 1'b0);
      wait_idle(200, "post_stall");

      begin
         int n;
         send_pkt(20, 2'd0, 1'b0, 1'b0, 1'b0);
         n = 0;
         while (exp_q.size() > 15 && n < 100) begin
            step(1);
            n++;
         end
         reset = 1'b1;
         #1;
         chk("midrst_outputs",
             32'({read_enb_o, m_valid, m_sop, m_eop, m_data, pkt_done, parity_err, addr_err, trunc_err}),
             32'd0);
         rq.delete();
         exp_q.delete();
         st_q.delete();
         step(2);
         reset = 1'b0;
         step(2);
         send_pkt(9, 2'd0, 1'b0, 1'b0, 1'b0);
         wait_idle(200, "post_rst");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout actual=running required=finished");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "global timeout");
   end

endmodule
